// File: rtl/me_pkg.sv
// Pipeline constants shared between the PE array and the SAD accumulation stages.
package me_pkg;

    localparam int PIX_W = 8;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    // Width that holds BLK_ROWS row sums of PE_NUM pixel differences without overflow.
    function automatic int sad_w(input int pe_num, input int blk_rows);
        return PIX_W + clog2(pe_num) + clog2(blk_rows);
    endfunction

endpackage

// File: rtl/sad_min_search_if.sv
// Handshake and result bundle between the PE array side and the SAD minimum search.
interface sad_min_search_if
    import me_pkg::*;
#(
    parameter int PE_NUM   = 16,
    parameter int BLK_ROWS = 16,
    parameter int SR       = 16,
    parameter int SAD_W    = sad_w(PE_NUM, BLK_ROWS)
);
    localparam int MV_W = clog2(2 * SR) + 1;

    logic                      start;
    logic                      ad_valid;
    logic [PE_NUM*PIX_W-1:0]   ad_bus;
    logic                      busy;
    logic                      done;
    logic [SAD_W-1:0]          best_sad;
    logic signed [MV_W-1:0]    best_mv_x;
    logic signed [MV_W-1:0]    best_mv_y;

    modport master (
        output start, ad_valid, ad_bus,
        input  busy, done, best_sad, best_mv_x, best_mv_y
    );

    modport slave (
        input  start, ad_valid, ad_bus,
        output busy, done, best_sad, best_mv_x, best_mv_y
    );

endinterface

// File: rtl/ad_sum_tree.sv
// Combinational unsigned adder tree over PE_NUM absolute-difference lanes.
module ad_sum_tree
    import me_pkg::*;
#(
    parameter int PE_NUM = 16,
    parameter int SUM_W  = PIX_W + clog2(PE_NUM)
) (
    input  logic [PE_NUM*PIX_W-1:0] ad_bus,
    output logic [SUM_W-1:0]        sum
);
    localparam int LVLS = clog2(PE_NUM);

    // Level l holds PE_NUM>>l partial sums; the last level is the total.
    for (genvar l = 0; l <= LVLS; l++) begin : g_lvl
        logic [SUM_W-1:0] node [PE_NUM>>l];
        if (l == 0) begin : g_leaf
            for (genvar j = 0; j < PE_NUM; j++) begin : g_lane
                assign node[j] = SUM_W'(ad_bus[PIX_W*j +: PIX_W]);
            end
        end else begin : g_add
            for (genvar j = 0; j < (PE_NUM >> l); j++) begin : g_pair
                assign node[j] = g_lvl[l-1].node[2*j] + g_lvl[l-1].node[2*j+1];
            end
        end
    end

    assign sum = g_lvl[LVLS].node[0];

endmodule

// File: rtl/sad_min_search.sv
// Accumulates per-candidate SADs from PE row sums and tracks the raster-first minimum
// with its motion vector over the full search window.
module sad_min_search
    import me_pkg::*;
#(
    parameter int PE_NUM   = 16,
    parameter int BLK_ROWS = 16,
    parameter int SR       = 16,
    parameter int SAD_W    = sad_w(PE_NUM, BLK_ROWS)
) (
    input  logic           clk,
    input  logic           rst,
    sad_min_search_if.slave bus
);
    localparam int SUM_W = PIX_W + clog2(PE_NUM);
    localparam int ROW_W = clog2(BLK_ROWS);
    localparam int CW    = clog2(2 * SR);
    localparam int MV_W  = CW + 1;

    // state   | meaning
    // IDLE    | waiting for start
    // RUN     | accepting beats, walking rows and candidates
    // DRAIN   | last beat accepted, pipeline emptying (2 cycles)
    // DONE    | best_* loaded, done pulse
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]             state;
    logic                   drain_cnt;
    logic [ROW_W-1:0]       row_cnt;
    logic [CW-1:0]          cand_x;
    logic [CW-1:0]          cand_y;
    logic                   beat;
    logic                   last_beat;
    logic signed [MV_W-1:0] mv_x;
    logic signed [MV_W-1:0] mv_y;

    logic [SUM_W-1:0]       row_sum;
    logic [SUM_W-1:0]       row_sum_q;
    logic                   s1_valid;
    logic                   s1_first;
    logic                   s1_last;
    logic signed [MV_W-1:0] s1_mv_x;
    logic signed [MV_W-1:0] s1_mv_y;

    logic                   s2_cand_done;
    logic [SAD_W-1:0]       acc_q;
    logic signed [MV_W-1:0] s2_mv_x;
    logic signed [MV_W-1:0] s2_mv_y;

    logic [SAD_W-1:0]       min_sad;
    logic signed [MV_W-1:0] min_mv_x;
    logic signed [MV_W-1:0] min_mv_y;
    logic                   cand_win;
    logic [SAD_W-1:0]       next_sad;
    logic signed [MV_W-1:0] next_mv_x;
    logic signed [MV_W-1:0] next_mv_y;

    logic [SAD_W-1:0]       best_sad;
    logic signed [MV_W-1:0] best_mv_x;
    logic signed [MV_W-1:0] best_mv_y;

    assign beat      = (state == S_RUN) && bus.ad_valid;
    assign last_beat = beat && (&row_cnt) && (&cand_x) && (&cand_y);
    assign mv_x      = {1'b0, cand_x} - MV_W'(SR);
    assign mv_y      = {1'b0, cand_y} - MV_W'(SR);

    ad_sum_tree #(
        .PE_NUM (PE_NUM),
        .SUM_W  (SUM_W)
    ) u_sum_tree (
        .ad_bus (bus.ad_bus),
        .sum    (row_sum)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            drain_cnt <= 1'b0;
            row_cnt   <= '0;
            cand_x    <= '0;
            cand_y    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state   <= S_RUN;
                        row_cnt <= '0;
                        cand_x  <= '0;
                        cand_y  <= '0;
                    end
                end
                S_RUN: begin
                    if (beat) begin
                        row_cnt <= row_cnt + ROW_W'(1);
                        if (&row_cnt) begin
                            cand_x <= cand_x + CW'(1);
                            if (&cand_x) cand_y <= cand_y + CW'(1);
                        end
                        if (last_beat) begin
                            state     <= S_DRAIN;
                            drain_cnt <= 1'b0;
                        end
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt) state <= S_DONE;
                    else           drain_cnt <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Strict compare keeps the raster-earliest candidate on ties.
    assign cand_win  = s2_cand_done && (acc_q < min_sad);
    assign next_sad  = cand_win ? acc_q   : min_sad;
    assign next_mv_x = cand_win ? s2_mv_x : min_mv_x;
    assign next_mv_y = cand_win ? s2_mv_y : min_mv_y;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid     <= 1'b0;
            s1_first     <= 1'b0;
            s1_last      <= 1'b0;
            row_sum_q    <= '0;
            s1_mv_x      <= '0;
            s1_mv_y      <= '0;
            s2_cand_done <= 1'b0;
            acc_q        <= '0;
            s2_mv_x      <= '0;
            s2_mv_y      <= '0;
            min_sad      <= '0;
            min_mv_x     <= '0;
            min_mv_y     <= '0;
            best_sad     <= '0;
            best_mv_x    <= '0;
            best_mv_y    <= '0;
        end else begin
            s1_valid <= beat;
            if (beat) begin
                row_sum_q <= row_sum;
                s1_first  <= (row_cnt == '0);
                s1_last   <= &row_cnt;
                s1_mv_x   <= mv_x;
                s1_mv_y   <= mv_y;
            end

            s2_cand_done <= s1_valid && s1_last;
            if (s1_valid) begin
                acc_q   <= s1_first ? SAD_W'(row_sum_q) : acc_q + SAD_W'(row_sum_q);
                s2_mv_x <= s1_mv_x;
                s2_mv_y <= s1_mv_y;
            end

            if (state == S_IDLE && bus.start) begin
                min_sad <= '1;
            end else if (cand_win) begin
                min_sad  <= acc_q;
                min_mv_x <= s2_mv_x;
                min_mv_y <= s2_mv_y;
            end

            // Final compare result lands directly in best_* on the DRAIN->DONE edge.
            if (state == S_DRAIN && drain_cnt) begin
                best_sad  <= next_sad;
                best_mv_x <= next_mv_x;
                best_mv_y <= next_mv_y;
            end
        end
    end

    assign bus.busy      = (state != S_IDLE);
    assign bus.done      = (state == S_DONE);
    assign bus.best_sad  = best_sad;
    assign bus.best_mv_x = best_mv_x;
    assign bus.best_mv_y = best_mv_y;

endmodule

// File: doc/sad_min_search.md
# sad_min_search

Block-matching SAD accumulator and minimum selector for the motion-estimation core. It sits directly downstream of the PE array: each valid beat it sums one row of absolute differences from `PE_NUM` processing elements. It accumulates `BLK_ROWS` beats into one candidate SAD, scans all candidate displacements in raster order, and reports the lowest SAD with its motion vector.

## Interface
- `PE_NUM`, 16: AD lanes per beat (power of 2, ≥2).
- `BLK_ROWS`, 16: beats per candidate (power of 2, ≥2).
- `SR`, 16: search range; `mv_x` and `mv_y` each span −SR..SR−1, giving (2·SR)² candidates.
- `SAD_W`, 8+clog2(PE_NUM)+clog2(BLK_ROWS): candidate SAD width, 16 at defaults.
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse that begins a block search.
- `ad_valid`  in  1  `ad_bus` carries one row of ADs this cycle.
- `ad_bus`  in  PE_NUM·8  lane i = bits [8i+7:8i], unsigned AD from PE i.
- `busy`  out  1  high from the cycle after an accepted `start` through the `done` cycle.
- `done`  out  1  one-cycle pulse; `best_*` are valid in the same cycle.
- `best_sad`  out  SAD_W  minimum candidate SAD.
- `best_mv_x`, `best_mv_y`  out  clog2(2·SR)+1 each  signed two's-complement displacement of the minimum.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE→RUN on `start`. Clear `row_cnt`, `cand_x` and `cand_y`; set `min_sad` to all-ones.
  - RUN→DRAIN on the accepted beat with `row_cnt`=BLK_ROWS−1, `cand_x`=2SR−1 and `cand_y`=2SR−1.
  - DRAIN→DONE when the pipeline is empty (2 cycles).
  - DONE→IDLE unconditionally after 1 cycle.
- Beats are counted only in RUN with `ad_valid`=1.
  - `ad_valid` in IDLE, DRAIN or DONE is ignored.
  - Gaps between beats are allowed; the internal state holds.
- `start` while `busy` is ignored and does not restart the search.
- Row sum: unsigned sum of all lanes, width 8+clog2(PE_NUM). Cannot overflow.
- Candidate SAD: the accumulator loads the row sum on the first row of each candidate and adds it on the others. Width SAD_W; cannot overflow.
- Compare: on a completed candidate, update `min_sad`/`min_mv` only if cand SAD < `min_sad` (strict).
  - On a tie the earliest candidate in raster order wins.
  - Candidate 0 always wins because its SAD is below all-ones.
- Motion vector: `mv_x` = `cand_x` − SR and `mv_y` = `cand_y` − SR.
  - `cand_x` wraps 2SR−1→0 and increments `cand_y` at the same time.
- Outputs `best_*` are registered and loaded only on entry to DONE. They hold their value until the next `done`.
- `rst` in any state, including mid-search: return to IDLE and clear accumulators.
  - `busy`, `done`, `best_sad` and `best_mv_*` all reset to 0.
  - No partial result is ever reported.

## Timing
- Pipeline for the beat accepted in cycle t:
  - t+1: row sum registered.
  - t+2: accumulator updated.
  - t+3: compare result registered into `min_*`.
- `done` and the final `best_*` are asserted 3 cycles after the last beat is accepted.
- `busy` rises in the cycle after `start` and falls the cycle after `done`.
- A new `start` is accepted in the cycle after `done` at the earliest.
- Throughput: one beat per cycle sustained. A full default search needs 1024·16 = 16384 beats plus 3 cycles.

## Structure
- Shared package `me_pkg` holds the pipeline constants shared with the PE array:
  - `PIX_W` = 8.
  - `clog2` function.
  - SAD width derivation.
- Sub-module `ad_sum_tree`: parameterised PE_NUM-input unsigned adder tree, purely combinational. Its output is registered in `sad_min_search`.
- FSM, counters, accumulator and comparator are kept in the top module.

## Test plan
- Reset values: assert `rst` for 2 cycles → `busy`=0, `done`=0, `best_sad`=0, `best_mv_x`=`best_mv_y`=0.
- Single minimum, PE_NUM=4, BLK_ROWS=2, SR=2 (16 candidates):
  - Stimulus: all lanes 10 except candidate (3,1), whose lanes are 1.
  - Expect `done` 3 cycles after the 32nd beat, `best_sad`=8, `best_mv_x`=+1, `best_mv_y`=−1.
- Tie: candidates 5 and 9 both have SAD 0, all others nonzero → `best_mv` of candidate 5 (`mv_x`=−1, `mv_y`=−1).
- Saturation: all lanes 255 at defaults → `best_sad`=65280, `best_mv`=(−16,−16), no overflow.
- Gapped `ad_valid` plus spurious inputs:
  - Random idle gaps and a `start` pulse mid-search give a result identical to the gap-free run.
  - `ad_valid` beats sent while in IDLE are ignored.
- Reset mid-search: `rst` after 20 beats → IDLE with no `done`. A fresh `start` then produces the correct result.
